// File: rtl/gng_romload_pkg.sv
// -----------------------------------------------------------------------------
// gng_romload_pkg
// Shared types and constants for the ROM download packer:
//   - state_t    : download controller states
//   - word_t     : one memory word {word address, data, byte enables}
//   - sig_byte() : expected ROM signature byte at byte addresses 0..3
// -----------------------------------------------------------------------------
package gng_romload_pkg;

    // Widest word address the 25-bit ioctl byte address can produce.
    localparam int WORD_ADDR_W = 24;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [15:0]            data;
        logic [1:0]             be;
    } word_t;

    // Signature 10 83 00 80 that unlocks the invulnerability option.
    function automatic logic [7:0] sig_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h10;
            2'd1:    return 8'h83;
            2'd2:    return 8'h00;
            default: return 8'h80;
        endcase
    endfunction

endpackage

// File: rtl/gng_romload_packer_fifo.sv
// -----------------------------------------------------------------------------
// gng_word_fifo
// Synchronous word FIFO with full/empty flags. A push and a pop in the same
// cycle both succeed even when full. A push while full without a pop is
// dropped; the caller detects that from push & full & ~pop.
// DEPTH must be a power of two and at least 2 (pointers wrap naturally).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (pointers only)
//   push, push_word   write strobe and entry
//   pop               read strobe, ignored when empty
//   head              entry at the read pointer (valid when !empty)
//   full, empty       occupancy flags
// -----------------------------------------------------------------------------
module gng_word_fifo
    import gng_romload_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t push_word,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

endmodule

// File: rtl/gng_romload_packer.sv
// -----------------------------------------------------------------------------
// gng_romload_packer
// Packs the HPS ioctl byte download into 16-bit little-endian words, buffers
// them in a small FIFO and hands them to the ROM/SDRAM write port over a
// req/ack handshake. Also latches the 4-byte invulnerability signature and
// reports load completion, FIFO overflow and out-of-range addresses.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ioctl_download        high for the whole download
//   ioctl_wr              one-cycle byte strobe
//   ioctl_addr[24:0]      byte address
//   ioctl_dout[7:0]       byte data
//   mem_req               word valid (head of FIFO)
//   mem_addr[ADDR_W-2:0]  word address
//   mem_data[15:0]        {odd byte, even byte}
//   mem_be[1:0]           bit0 even byte, bit1 odd byte
//   mem_ack               pop strobe, ignored while mem_req is low
//   load_done             download finished and everything drained
//   sig_match             bytes 0..3 matched the signature
//   overflow              sticky, a word was dropped
//   range_err             sticky, a byte address was >= 2^ADDR_W
// -----------------------------------------------------------------------------
module gng_romload_packer
    import gng_romload_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    output logic              load_done,
    output logic              sig_match,
    output logic              overflow,
    output logic              range_err
);

    function automatic word_t make_word(input logic [WORD_ADDR_W-1:0] a,
                                        input logic [15:0]            d,
                                        input logic [1:0]             be);
        word_t w;
        w.addr = a;
        w.data = d;
        w.be   = be;
        return w;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic                   dl_q;
    logic                   dl_rise;
    logic                   dl_fall;
    logic                   enter_load;
    logic                   flush_now;
    logic                   wr_ok;
    logic                   in_range;
    logic                   byte_ok;
    logic                   odd_byte;
    logic [WORD_ADDR_W-1:0] waddr;
    logic                   drained;

    logic                   pend_vld;
    logic [WORD_ADDR_W-1:0] pend_addr;
    logic [7:0]             pend_byte;
    logic                   pend_set;
    logic                   pend_clr;

    word_t                  c0;
    word_t                  c1;
    logic                   c0_vld;
    logic                   c1_vld;

    word_t                  skid_word;
    word_t                  skid_d;
    logic                   skid_vld;
    logic                   skid_vld_d;

    word_t                  word_d;
    logic                   vld_d;
    word_t                  word_p1;
    logic                   vld_p1;
    logic                   stage_drop;

    logic [3:0]             sig_flags;

    word_t                  fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign enter_load = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && dl_rise;
    assign flush_now  = (state_q == ST_LOAD) && dl_fall;
    assign wr_ok      = (state_q == ST_LOAD) && ioctl_wr && ioctl_download;
    assign in_range   = ((ioctl_addr >> ADDR_W) == '0);
    assign byte_ok    = wr_ok & in_range;
    assign odd_byte   = ioctl_addr[0];
    assign waddr      = ioctl_addr[24:1];
    assign drained    = fifo_empty & ~vld_p1 & ~skid_vld & ~pend_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (dl_rise) state_d = ST_LOAD;
            ST_LOAD:  if (dl_fall) state_d = ST_FLUSH;
            ST_FLUSH: if (drained) state_d = ST_DONE;
            ST_DONE:  if (dl_rise) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobe stage: decide up to two word pushes (in order) for this byte.
    always_comb begin
        c0       = '0;
        c1       = '0;
        c0_vld   = 1'b0;
        c1_vld   = 1'b0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (byte_ok) begin
            if (!odd_byte) begin
                pend_set = 1'b1;
                if (pend_vld) begin
                    c0_vld = 1'b1;
                    c0     = make_word(pend_addr, {8'h00, pend_byte}, BE_LO);
                end
            end else if (pend_vld && (pend_addr == waddr)) begin
                pend_clr = 1'b1;
                c0_vld   = 1'b1;
                c0       = make_word(waddr, {ioctl_dout, pend_byte}, BE_BOTH);
            end else if (pend_vld) begin
                // Stale even half goes first; the odd byte follows via the skid.
                pend_clr = 1'b1;
                c0_vld   = 1'b1;
                c0       = make_word(pend_addr, {8'h00, pend_byte}, BE_LO);
                c1_vld   = 1'b1;
                c1       = make_word(waddr, {ioctl_dout, 8'h00}, BE_HI);
            end else begin
                c0_vld = 1'b1;
                c0     = make_word(waddr, {ioctl_dout, 8'h00}, BE_HI);
            end
        end else if (flush_now && pend_vld) begin
            pend_clr = 1'b1;
            c0_vld   = 1'b1;
            c0       = make_word(pend_addr, {8'h00, pend_byte}, BE_LO);
        end
    end

    // One push per cycle: an occupied skid entry is older than anything new.
    // A third word in one cycle has nowhere to go and counts as an overflow.
    always_comb begin
        vld_d      = c0_vld;
        word_d     = c0;
        skid_vld_d = c1_vld;
        skid_d     = c1;
        stage_drop = 1'b0;
        if (skid_vld) begin
            vld_d      = 1'b1;
            word_d     = skid_word;
            skid_vld_d = c0_vld;
            skid_d     = c0;
            stage_drop = c1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dl_q      <= 1'b0;
            pend_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            vld_p1    <= 1'b0;
            sig_flags <= '0;
            sig_match <= 1'b0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            dl_q     <= ioctl_download;
            vld_p1   <= vld_d;
            skid_vld <= skid_vld_d;
            if (pend_set)      pend_vld <= 1'b1;
            else if (pend_clr) pend_vld <= 1'b0;
            if (enter_load) begin
                sig_flags <= '0;
                sig_match <= 1'b0;
                overflow  <= 1'b0;
                range_err <= 1'b0;
            end else begin
                if (wr_ok && !in_range) range_err <= 1'b1;
                if (stage_drop || (vld_p1 && fifo_full && !fifo_pop)) overflow <= 1'b1;
                if (byte_ok && (ioctl_addr[24:2] == '0))
                    sig_flags[ioctl_addr[1:0]] <= (ioctl_dout == sig_byte(ioctl_addr[1:0]));
                sig_match <= &sig_flags;
            end
        end
    end

    // Push stage (_p1): words enter the FIFO the cycle after the strobe.
    always_ff @(posedge clk) begin
        if (pend_set) begin
            pend_addr <= waddr;
            pend_byte <= ioctl_dout;
        end
        word_p1   <= word_d;
        skid_word <= skid_d;
    end

    gng_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (vld_p1),
        .push_word(word_p1),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // FIFO head is register storage; fields are forced to 0 while idle so
    // every output reads 0 out of reset.
    assign mem_req   = ~fifo_empty;
    assign fifo_pop  = mem_ack & mem_req;
    assign mem_addr  = mem_req ? fifo_head.addr[ADDR_W-2:0] : '0;
    assign mem_data  = mem_req ? fifo_head.data : '0;
    assign mem_be    = mem_req ? fifo_head.be : '0;
    assign load_done = (state_q == ST_DONE);

    generate
        if (ADDR_W - 1 < WORD_ADDR_W) begin : g_addr_sink
            logic unused_addr_hi;
            assign unused_addr_hi = ^fifo_head.addr[WORD_ADDR_W-1:ADDR_W-1];
        end
    endgenerate

endmodule

// File: tb/tb_gng_romload_packer.sv
module tb_gng_romload_packer;

    localparam int ADDR_W = 19;
    localparam int WA_W   = ADDR_W - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ioctl_download = 1'b0;
    logic            ioctl_wr = 1'b0;
    logic [24:0]     ioctl_addr = '0;
    logic [7:0]      ioctl_dout = '0;
    logic            mem_ack = 1'b0;
    logic            mem_req;
    logic [WA_W-1:0] mem_addr;
    logic [15:0]     mem_data;
    logic [1:0]      mem_be;
    logic            load_done;
    logic            sig_match;
    logic            overflow;
    logic            range_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb[$];
    bit          ack_en  = 1'b1;

    gng_romload_packer #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .load_done     (load_done),
        .sig_match     (sig_match),
        .overflow      (overflow),
        .range_err     (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wexp(input int unsigned a, input logic [15:0] d,
                                         input logic [1:0] be);
        logic [WA_W-1:0] aw;
        aw = a[WA_W-1:0];
        return {28'd0, aw, d, be};
    endfunction

    function automatic logic [63:0] cur_word();
        return {28'd0, mem_addr, mem_data, mem_be};
    endfunction

    // Memory side: ack each word one cycle after it appears, checking it
    // against the scoreboard as it is popped.
    initial begin : monitor
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (ack_en && mem_req) begin
                if (seen) begin
                    if (sb.size() == 0) check("unexpected_word", 64'(mem_req), 64'd0);
                    else check("word", cur_word(), sb.pop_front());
                    mem_ack = 1'b1;
                    seen    = 1'b0;
                end else begin
                    seen = 1'b1;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk);
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        @(negedge clk);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!load_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("load_done", 64'(load_done), 64'd1);
    endtask

    task automatic sig_download(input logic [7:0] b3, input logic exp_match, input bit check_lat);
        start_dl();
        check("sig_clr", 64'(sig_match), 64'd0);
        check("done_clr", 64'(load_done), 64'd0);
        sb.push_back(wexp(0, 16'h8310, 2'b11));
        sb.push_back(wexp(1, {b3, 8'h00}, 2'b11));
        wr_byte(25'd0, 8'h10);
        wr_byte(25'd1, 8'h83);
        if (check_lat) begin
            check("lat_pre", 64'(mem_req), 64'd0);
            @(negedge clk);
            check("lat_req", 64'(mem_req), 64'd1);
        end
        wr_byte(25'd2, 8'h00);
        wr_byte(25'd3, b3);
        wait_drain(40);
        end_dl();
        wait_done(40);
        check("sig_match", 64'(sig_match), 64'(exp_match));
    endtask

    initial begin : main
        logic        got_req;
        logic [63:0] w0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_sig", 64'(sig_match), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_rng", 64'(range_err), 64'd0);

        // Signature: good, bad, good again
        sig_download(8'h80, 1'b1, 1'b1);
        sig_download(8'h81, 1'b0, 1'b0);
        sig_download(8'h80, 1'b1, 1'b0);

        // Lone even byte flushed at download end
        start_dl();
        sb.push_back(wexp(3, 16'h005A, 2'b01));
        wr_byte(25'd6, 8'h5A);
        repeat (3) @(negedge clk);
        check("pend_no_req", 64'(mem_req), 64'd0);
        end_dl();
        wait_done(40);
        wait_drain(10);

        // FIFO overflow with memory stalled
        ack_en = 1'b0;
        start_dl();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] lo;
            lo = 8'hA0 + 8'(2 * i);
            sb.push_back(wexp(i, {lo + 8'h01, lo}, 2'b11));
        end
        w0 = sb[0];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (4) @(negedge clk);
        check("ovf_set", 64'(overflow), 64'd1);
        check("hold_req0", 64'(mem_req), 64'd1);
        check("hold_word0", cur_word(), w0);
        repeat (3) @(negedge clk);
        check("hold_req1", 64'(mem_req), 64'd1);
        check("hold_word1", cur_word(), w0);
        ack_en = 1'b1;
        wait_drain(60);
        end_dl();
        wait_done(40);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Out-of-range byte address
        start_dl();
        check("ovf_clr", 64'(overflow), 64'd0);
        wr_byte(25'h80000, 8'h55);
        repeat (3) @(negedge clk);
        check("rng_set", 64'(range_err), 64'd1);
        check("rng_no_req", 64'(mem_req), 64'd0);
        end_dl();
        wait_done(40);
        check("rng_sticky", 64'(range_err), 64'd1);

        // Reset in the middle of a stalled download
        ack_en = 1'b0;
        start_dl();
        wr_byte(25'd0, 8'h10);
        wr_byte(25'd1, 8'h83);
        wr_byte(25'd2, 8'h00);
        wr_byte(25'd3, 8'h80);
        repeat (3) @(negedge clk);
        check("pre_rst_req", 64'(mem_req), 64'd1);
        check("pre_rst_sig", 64'(sig_match), 64'd1);
        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk);
        check("mrst_outs", {mem_req, mem_addr, mem_data, mem_be, load_done, sig_match,
                            overflow, range_err}, 64'd0);
        rst_n = 1'b1;
        sb.delete();
        ack_en  = 1'b1;
        got_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            got_req |= mem_req;
        end
        check("mrst_no_req", 64'(got_req), 64'd0);

        // Odd byte first, then its even partner stays pending until the end
        start_dl();
        sb.push_back(wexp(2, 16'h7700, 2'b10));
        sb.push_back(wexp(2, 16'h0044, 2'b01));
        wr_byte(25'd5, 8'h77);
        wr_byte(25'd4, 8'h44);
        repeat (6) @(negedge clk);
        check("odd_first_left", 64'(sb.size()), 64'd1);
        end_dl();
        wait_done(40);
        wait_drain(10);

        // Pending even half displaced by an odd byte of another word
        start_dl();
        sb.push_back(wexp(2, 16'h0044, 2'b01));
        sb.push_back(wexp(4, 16'h9900, 2'b10));
        wr_byte(25'd4, 8'h44);
        wr_byte(25'd9, 8'h99);
        wait_drain(40);
        end_dl();
        wait_done(40);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
